// File: rtl/ntt_seq.sv
// ntt_seq: job sequencer for a polynomial NTT engine.
// Runs 1..MAX_POLY polynomials back to back. Each polynomial takes 1024 AGU
// butterflies, then a drain window so the butterfly pipeline empties before
// the next polynomial starts. Coefficient RAM addresses are {poly, addr}.
// Between jobs the host may borrow the RAM port.
//
// Start handshake: a job is accepted on the rising edge where start_i=1, the
// sequencer is IDLE and 1 <= npoly_i <= MAX_POLY. busy_o rises on that edge.
// A start outside IDLE, or with an illegal count, is dropped and never queued.
// done_o pulses for one cycle at the end of the job, and the sequencer is
// back in IDLE on the following cycle.
module ntt_seq #(
    parameter int BF_LAT   = 3,
    parameter int MAX_POLY = 7
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [2:0]  npoly_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        agu_en_o,
    input  logic [7:0]  agu_addrA_i,
    input  logic [7:0]  agu_addrB_i,
    input  logic [7:0]  agu_zeta_i,
    input  logic        agu_wren_i,
    output logic [10:0] rd_addrA_o,
    output logic [10:0] rd_addrB_o,
    output logic [7:0]  zeta_addr_o,
    output logic [10:0] wr_addrA_o,
    output logic [10:0] wr_addrB_o,
    output logic        wr_en_o,
    input  logic        host_req_i,
    input  logic [10:0] host_addr_i,
    output logic        host_gnt_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Largest legal polynomial count, clamped to what the 3-bit input can express.
    localparam logic [3:0]  LP_MAX_POLY = (MAX_POLY > 7) ? 4'd7 : 4'(MAX_POLY);
    localparam logic [2:0]  LP_LAT      = 3'(BF_LAT);
    localparam logic [10:0] LP_LAST_BF  = 11'd1023;

    state_t      r_state;
    logic [2:0]  r_poly;
    logic [2:0]  r_npoly;
    logic [10:0] r_bfly_cnt;
    logic [2:0]  r_drain_cnt;
    logic        r_busy;
    logic        r_agu_en;
    logic        r_done;

    logic        r_pipe_vld [BF_LAT];
    logic [10:0] r_pipe_a   [BF_LAT];
    logic [10:0] r_pipe_b   [BF_LAT];

    logic        w_idle;
    logic        w_run;
    logic        w_host_gnt;
    logic        w_npoly_ok;
    logic        w_bf_vld;
    logic [10:0] w_rd_a;
    logic [10:0] w_rd_b;
    logic [7:0]  w_zeta;
    logic [10:0] w_wr_a;
    logic [10:0] w_wr_b;
    logic        w_wr_en;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_run      = (r_state == ST_RUN);
    assign w_host_gnt = host_req_i && w_idle;
    assign w_npoly_ok = (npoly_i != 3'd0) && ({1'b0, npoly_i} <= LP_MAX_POLY);
    assign w_bf_vld   = agu_wren_i && w_run;

    // Sequencer FSM; busy/agu_en/done are registered alongside the state change.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_poly      <= 3'd0;
            r_npoly     <= 3'd0;
            r_bfly_cnt  <= 11'd0;
            r_drain_cnt <= 3'd0;
            r_busy      <= 1'b0;
            r_agu_en    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i && w_npoly_ok) begin
                        r_state    <= ST_RUN;
                        r_poly     <= 3'd0;
                        r_npoly    <= npoly_i;
                        r_bfly_cnt <= 11'd0;
                        r_busy     <= 1'b1;
                        r_agu_en   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (agu_wren_i) begin
                        r_bfly_cnt <= r_bfly_cnt + 11'd1;
                        if (r_bfly_cnt == LP_LAST_BF) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= LP_LAT;
                            r_agu_en    <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == 3'd0) begin
                        if (r_poly == r_npoly - 3'd1) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 3'd1;
                    end
                end
                ST_NEXT: begin
                    r_state    <= ST_RUN;
                    r_poly     <= r_poly + 3'd1;
                    r_bfly_cnt <= 11'd0;
                    r_agu_en   <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_agu_en <= 1'b0;
                end
            endcase
        end
    end

    // Write-back pipeline: carries each butterfly's addresses to its write slot.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < BF_LAT; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_a[i]   <= 11'd0;
                r_pipe_b[i]   <= 11'd0;
            end
        end else begin
            r_pipe_vld[0] <= w_bf_vld;
            r_pipe_a[0]   <= w_rd_a;
            r_pipe_b[0]   <= w_rd_b;
            for (int i = 1; i < BF_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_a[i]   <= r_pipe_a[i-1];
                r_pipe_b[i]   <= r_pipe_b[i-1];
            end
        end
    end

    // Read port mux: AGU during RUN, host when granted, otherwise parked at 0.
    always_comb begin
        w_rd_a = 11'd0;
        w_rd_b = 11'd0;
        w_zeta = 8'd0;
        if (w_run) begin
            w_rd_a = {r_poly, agu_addrA_i};
            w_rd_b = {r_poly, agu_addrB_i};
            w_zeta = agu_zeta_i;
        end else if (w_host_gnt) begin
            w_rd_a = host_addr_i;
        end
    end

    // Write port mux: pipeline output while busy, host address or 0 in IDLE.
    always_comb begin
        w_wr_en = 1'b0;
        w_wr_a  = 11'd0;
        w_wr_b  = 11'd0;
        if (w_idle) begin
            if (w_host_gnt) begin
                w_wr_a = host_addr_i;
            end
        end else begin
            w_wr_en = r_pipe_vld[BF_LAT-1];
            w_wr_a  = r_pipe_a[BF_LAT-1];
            w_wr_b  = r_pipe_b[BF_LAT-1];
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign agu_en_o    = r_agu_en;
    assign rd_addrA_o  = w_rd_a;
    assign rd_addrB_o  = w_rd_b;
    assign zeta_addr_o = w_zeta;
    assign wr_addrA_o  = w_wr_a;
    assign wr_addrB_o  = w_wr_b;
    assign wr_en_o     = w_wr_en;
    assign host_gnt_o  = w_host_gnt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ntt_seq.sv
// tb_ntt_seq: randomized bench for ntt_seq with a timeline reference model.
`timescale 1ns/1ps
module tb_ntt_seq;

    localparam int BF_LAT   = 3;
    localparam int MAX_POLY = 7;
    localparam int EW       = 54;   // {due cycle[31:0], wr_addrA[10:0], wr_addrB[10:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic        start_i;
    logic [2:0]  npoly_i;
    logic        busy_o;
    logic        done_o;
    logic        agu_en_o;
    logic [7:0]  agu_addrA_i;
    logic [7:0]  agu_addrB_i;
    logic [7:0]  agu_zeta_i;
    logic        agu_wren_i;
    logic [10:0] rd_addrA_o;
    logic [10:0] rd_addrB_o;
    logic [7:0]  zeta_addr_o;
    logic [10:0] wr_addrA_o;
    logic [10:0] wr_addrB_o;
    logic        wr_en_o;
    logic        host_req_i;
    logic [10:0] host_addr_i;
    logic        host_gnt_o;
    logic [2:0]  dbg_state_o;

    ntt_seq #(.BF_LAT(BF_LAT), .MAX_POLY(MAX_POLY)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .npoly_i     (npoly_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .agu_en_o    (agu_en_o),
        .agu_addrA_i (agu_addrA_i),
        .agu_addrB_i (agu_addrB_i),
        .agu_zeta_i  (agu_zeta_i),
        .agu_wren_i  (agu_wren_i),
        .rd_addrA_o  (rd_addrA_o),
        .rd_addrB_o  (rd_addrB_o),
        .zeta_addr_o (zeta_addr_o),
        .wr_addrA_o  (wr_addrA_o),
        .wr_addrB_o  (wr_addrB_o),
        .wr_en_o     (wr_en_o),
        .host_req_i  (host_req_i),
        .host_addr_i (host_addr_i),
        .host_gnt_o  (host_gnt_o),
        .dbg_state_o (dbg_state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- AGU driver ----------------
    // Issues 1024 randomly spaced butterflies while enabled, restarts when disabled.
    int agu_cnt  = 0;
    bit spurious = 1'b0;

    always @(negedge clk) begin
        if (agu_en_o === 1'b1 && agu_cnt < 1024) begin
            agu_wren_i = ($urandom_range(0, 3) != 0);
            if (agu_wren_i) agu_cnt++;
        end else begin
            if (agu_en_o !== 1'b1) agu_cnt = 0;
            agu_wren_i = spurious && ($urandom_range(0, 1) == 1);
        end
        agu_addrA_i = 8'($urandom);
        agu_addrB_i = 8'($urandom);
        agu_zeta_i  = 8'($urandom);
    end

    // ---------------- reference model + scoreboard ----------------
    // Job timeline: RUN until 1024 strobes, then BF_LAT+1 drain cycles, then a
    // NEXT or DONE cycle. Writes land BF_LAT cycles after their strobe.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] head;
    int  cyc = 0;
    bit  chk_en = 1'b0;
    bit  m_busy = 1'b0;
    bit  m_in_run = 1'b0;
    int  m_poly = 0;
    int  m_npoly = 0;
    int  m_cnt = 0;
    int  m_resume_cyc = -1;
    int  m_done_cyc = -1;
    int  m_end_cyc = -1;
    bit  exp_busy, exp_en, exp_done, exp_gnt, exp_we;
    logic [10:0] exp_ra, exp_rb, exp_wa, exp_wb;
    logic [7:0]  exp_z;

    int n_wr = 0;
    int n_done = 0;
    logic [7:0] poly_mask = 8'd0;
    int low_len = 0;
    bit had_run = 1'b0;
    int gap_min = 999;
    int gap_max = 0;

    always @(negedge clk) begin
        #3;
        cyc++;
        if (m_busy && cyc == m_end_cyc) m_busy = 1'b0;
        if (m_busy && !m_in_run && cyc == m_resume_cyc) begin
            m_in_run = 1'b1;
            m_poly++;
            m_cnt = 0;
        end
        exp_busy = m_busy;
        exp_en   = m_busy && m_in_run;
        exp_done = m_busy && (cyc == m_done_cyc);
        exp_gnt  = !m_busy && host_req_i;
        exp_ra = 11'd0; exp_rb = 11'd0; exp_z = 8'd0;
        if (exp_en) begin
            exp_ra = {m_poly[2:0], agu_addrA_i};
            exp_rb = {m_poly[2:0], agu_addrB_i};
            exp_z  = agu_zeta_i;
        end else if (exp_gnt) begin
            exp_ra = host_addr_i;
        end
        exp_we = 1'b0;
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            if (int'(head[53:22]) == cyc) exp_we = 1'b1;
        end

        if (chk_en) begin
            n_checks++;
            if (busy_o !== exp_busy) begin
                n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, exp_busy);
            end
            n_checks++;
            if (agu_en_o !== exp_en) begin
                n_fail++; $display("FAIL agu_en cyc=%0d got=%b exp=%b", cyc, agu_en_o, exp_en);
            end
            n_checks++;
            if (done_o !== exp_done) begin
                n_fail++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done_o, exp_done);
            end
            n_checks++;
            if (host_gnt_o !== exp_gnt) begin
                n_fail++; $display("FAIL host_gnt cyc=%0d got=%b exp=%b", cyc, host_gnt_o, exp_gnt);
            end
            n_checks++;
            if (rd_addrA_o !== exp_ra || rd_addrB_o !== exp_rb || zeta_addr_o !== exp_z) begin
                n_fail++;
                $display("FAIL rd_path cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc,
                         rd_addrA_o, rd_addrB_o, zeta_addr_o, exp_ra, exp_rb, exp_z);
            end
            n_checks++;
            if (wr_en_o !== exp_we) begin
                n_fail++; $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, wr_en_o, exp_we);
            end
            if (exp_we) begin
                n_checks++;
                if (wr_addrA_o !== head[21:11] || wr_addrB_o !== head[10:0]) begin
                    n_fail++;
                    $display("FAIL wr_addr cyc=%0d got=%h/%h exp=%h/%h", cyc,
                             wr_addrA_o, wr_addrB_o, head[21:11], head[10:0]);
                end
            end else if (!exp_busy) begin
                exp_wa = exp_gnt ? host_addr_i : 11'd0;
                exp_wb = 11'd0;
                n_checks++;
                if (wr_addrA_o !== exp_wa || wr_addrB_o !== exp_wb) begin
                    n_fail++;
                    $display("FAIL idle_wr_addr cyc=%0d got=%h/%h exp=%h/%h", cyc,
                             wr_addrA_o, wr_addrB_o, exp_wa, exp_wb);
                end
            end
        end
        if (exp_we) void'(exp_q.pop_front());

        // observation statistics for the scenario tasks
        if (wr_en_o === 1'b1) begin
            n_wr++;
            poly_mask = poly_mask | 8'(1 << wr_addrA_o[10:8]);
        end
        if (done_o === 1'b1) n_done++;
        if (agu_en_o === 1'b1) begin
            if (had_run && low_len > 0) begin
                if (low_len < gap_min) gap_min = low_len;
                if (low_len > gap_max) gap_max = low_len;
            end
            low_len = 0;
            had_run = 1'b1;
        end else if (busy_o === 1'b1) begin
            low_len++;
        end else begin
            low_len = 0;
            had_run = 1'b0;
        end

        // effect of this cycle's inputs at the coming rising edge
        if (rst_ni !== 1'b1) begin
            m_busy = 1'b0; m_in_run = 1'b0; m_poly = 0; m_cnt = 0;
            m_resume_cyc = -1; m_done_cyc = -1; m_end_cyc = -1;
            exp_q.delete();
        end else begin
            if (m_in_run && agu_wren_i === 1'b1) begin
                exp_q.push_back({32'(cyc + BF_LAT), m_poly[2:0], agu_addrA_i, m_poly[2:0], agu_addrB_i});
                m_cnt++;
                if (m_cnt == 1024) begin
                    m_in_run = 1'b0;
                    if (m_poly == m_npoly - 1) begin
                        m_done_cyc = cyc + BF_LAT + 2;
                        m_end_cyc  = cyc + BF_LAT + 3;
                    end else begin
                        m_resume_cyc = cyc + BF_LAT + 3;
                    end
                end
            end
            if (!m_busy && start_i === 1'b1 && int'(npoly_i) >= 1 && int'(npoly_i) <= MAX_POLY) begin
                m_busy = 1'b1; m_in_run = 1'b0; m_poly = -1; m_npoly = int'(npoly_i);
                m_resume_cyc = cyc + 1; m_done_cyc = -1; m_end_cyc = -1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #4;
            if (done_o === 1'b1) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL wait_done timeout got=no_done exp=done within %0d", max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; npoly_i = 3'd0; host_req_i = 1'b0; host_addr_i = 11'd0;
        repeat (3) @(negedge clk);
        #4;
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || agu_en_o !== 1'b0 || wr_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b%b%b%b exp=0000", busy_o, done_o, agu_en_o, wr_en_o);
        end
        n_checks++;
        if (rd_addrA_o !== 11'd0 || wr_addrA_o !== 11'd0 || host_gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_addr got=%h/%h/%b exp=0/0/0", rd_addrA_o, wr_addrA_o, host_gnt_o);
        end
        @(negedge clk);
        host_req_i = 1'b1; host_addr_i = 11'h155;
        #4;
        n_checks++;
        if (host_gnt_o !== 1'b1 || rd_addrA_o !== 11'h155) begin
            n_fail++;
            $display("FAIL reset_host got=%b/%h exp=1/155", host_gnt_o, rd_addrA_o);
        end
        chk_en = 1'b1;
        @(negedge clk);
        host_req_i = 1'b0;
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        n_wr = 0; n_done = 0;
        @(negedge clk); start_i = 1'b1; npoly_i = 3'd1;
        @(negedge clk); start_i = 1'b0; #4;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL single_busy_next got=%b exp=1", busy_o);
        end
        wait_done(3000);
        @(negedge clk); #4;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL single_busy_after got=%b exp=0", busy_o);
        end
        n_checks++;
        if (n_wr != 1024 || n_done != 1) begin
            n_fail++; $display("FAIL single_counts got=%0d/%0d exp=1024/1", n_wr, n_done);
        end
    endtask

    task automatic test_multi();
        n_wr = 0; n_done = 0; poly_mask = 8'd0; gap_min = 999; gap_max = 0;
        @(negedge clk); start_i = 1'b1; npoly_i = 3'd3;
        @(negedge clk); start_i = 1'b0;
        wait_done(8000);
        repeat (2) @(negedge clk);
        n_checks++;
        if (n_wr != 3072 || poly_mask !== 8'h07) begin
            n_fail++; $display("FAIL multi_writes got=%0d/%h exp=3072/07", n_wr, poly_mask);
        end
        n_checks++;
        if (gap_min != BF_LAT + 2 || gap_max != BF_LAT + 2) begin
            n_fail++; $display("FAIL multi_gap got=%0d..%0d exp=%0d", gap_min, gap_max, BF_LAT + 2);
        end
    endtask

    task automatic test_back_to_back();
        n_wr = 0; n_done = 0; poly_mask = 8'd0;
        @(negedge clk); start_i = 1'b1; npoly_i = 3'd0;
        @(negedge clk); start_i = 1'b1; npoly_i = 3'd7; #4;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL zero_poly_ignored got=%b exp=0", busy_o);
        end
        @(negedge clk); start_i = 1'b0; #4;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL seven_poly_started got=%b exp=1", busy_o);
        end
        wait_done(15000);
        repeat (2) @(negedge clk);
        n_checks++;
        if (n_wr != 7168 || n_done != 1 || poly_mask !== 8'h7F) begin
            n_fail++; $display("FAIL seven_poly_writes got=%0d/%0d/%h exp=7168/1/7f", n_wr, n_done, poly_mask);
        end
    endtask

    task automatic test_host();
        n_wr = 0;
        spurious = 1'b1;
        @(negedge clk); host_req_i = 1'b1; host_addr_i = 11'h2A5; start_i = 1'b1; npoly_i = 3'd1; #4;
        n_checks++;
        if (host_gnt_o !== 1'b1 || rd_addrA_o !== 11'h2A5) begin
            n_fail++; $display("FAIL host_with_start got=%b/%h exp=1/2a5", host_gnt_o, rd_addrA_o);
        end
        @(negedge clk); start_i = 1'b0; #4;
        n_checks++;
        if (host_gnt_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL host_during_job got=%b/%b exp=0/1", host_gnt_o, busy_o);
        end
        wait_done(3000);
        @(negedge clk); #4;
        n_checks++;
        if (host_gnt_o !== 1'b1 || rd_addrA_o !== 11'h2A5 || wr_addrA_o !== 11'h2A5 ||
            rd_addrB_o !== 11'd0 || wr_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL host_after_job got=%b/%h/%h/%h/%b exp=1/2a5/2a5/0/0",
                     host_gnt_o, rd_addrA_o, wr_addrA_o, rd_addrB_o, wr_en_o);
        end
        n_checks++;
        if (n_wr != 1024) begin
            n_fail++; $display("FAIL host_job_writes got=%0d exp=1024", n_wr);
        end
        repeat (5) @(negedge clk);
        @(negedge clk); host_req_i = 1'b0; spurious = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        n_done = 0;
        @(negedge clk); start_i = 1'b1; npoly_i = 3'd3;
        @(negedge clk); start_i = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (m_poly == 1 && m_in_run && m_cnt >= 500) begin hit = 1'b1; break; end
        end
        n_checks++;
        if (!hit) begin
            n_fail++; $display("FAIL reset_mid_reach got=not_reached exp=poly1_bfly500");
        end
        rst_ni = 1'b0;
        @(negedge clk); rst_ni = 1'b1; #4;
        n_checks++;
        if (busy_o !== 1'b0 || agu_en_o !== 1'b0 || wr_en_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs got=%b%b%b exp=000", busy_o, agu_en_o, wr_en_o);
        end
        n_wr = 0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_wr != 0 || n_done != 0) begin
            n_fail++; $display("FAIL reset_mid_quiet got=%0d/%0d exp=0/0", n_wr, n_done);
        end
        n_wr = 0;
        @(negedge clk); start_i = 1'b1; npoly_i = 3'd2;
        @(negedge clk); start_i = 1'b0;
        wait_done(6000);
        repeat (2) @(negedge clk);
        n_checks++;
        if (n_wr != 2048 || n_done != 1) begin
            n_fail++; $display("FAIL reset_mid_rerun got=%0d/%0d exp=2048/1", n_wr, n_done);
        end
    endtask

    task automatic test_start_held();
        n_done = 0; n_wr = 0;
        @(negedge clk); start_i = 1'b1; npoly_i = 3'd2;
        wait_done(6000);
        @(negedge clk); #4;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL held_idle_gap got=%b exp=0", busy_o);
        end
        @(negedge clk); #4;
        n_checks++;
        if (busy_o !== 1'b1 || n_done != 1) begin
            n_fail++; $display("FAIL held_second_start got=%b/%0d exp=1/1", busy_o, n_done);
        end
        @(negedge clk); start_i = 1'b0;
        wait_done(6000);
        repeat (2) @(negedge clk);
        n_checks++;
        if (n_done != 2 || n_wr != 4096) begin
            n_fail++; $display("FAIL held_two_jobs got=%0d/%0d exp=2/4096", n_done, n_wr);
        end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_host();
        test_reset_mid();
        test_start_held();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain got=%0d exp=0 pending writes", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
